// File: rtl/led_output_port_pkg.sv
// Shared definitions for the LED output port: bus address and display FSM encoding.
package led_output_port_pkg;

  // Word address the CPU stores to in order to drive the board LEDs.
  localparam logic [31:0] LED_BASE_ADDR = 32'h8000_0000;

  // Display FSM: IDLE waits for data, SHOW holds a value for the hold time.
  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } disp_state_t;

  // Width of a down-counter that must hold HOLD_CYCLES-1 (at least one bit).
  function automatic int hold_cnt_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth. dout shows the oldest entry
// whenever the FIFO is non-empty; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_25mhz,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_25mhz) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/led_output_port.sv
// Memory-mapped LED port. CPU stores to BASE_ADDR are queued in a FIFO and
// each value is shown on the LEDs for HOLD_CYCLES clocks so fast store
// sequences stay visible. Stores stall while the FIFO is full.
// Optional macro LED_READBACK_EN: loads from BASE_ADDR return
// {fifo_count in [31:24], led in [LED_WIDTH-1:0]}; otherwise rdata is 0.
module led_output_port
  import led_output_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = LED_BASE_ADDR,
  parameter int          DEPTH       = 4,
  parameter int          HOLD_CYCLES = 25_000_000,
  parameter int          LED_WIDTH   = 8
) (
  input  logic                   clk_25mhz,
  input  logic                   reset_n,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  input  logic                   write_en,
  input  logic                   read_en,
  output logic [31:0]            rdata,
  output logic                   stall,
  output logic [LED_WIDTH-1:0]   led,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int             HW        = hold_cnt_w(HOLD_CYCLES);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic                 hit, push, pop, full, empty;
  logic [LED_WIDTH-1:0] fifo_dout;
  disp_state_t          state;
  logic [HW-1:0]        hold_cnt;

  assign hit   = (addr == BASE_ADDR);
  assign push  = write_en && hit && !full;
  // full is decoded from the registered count, so a same-cycle pop never
  // releases the stall; the CPU retries and lands on the next cycle.
  assign stall = write_en && hit && full;
  // Empty is registered too, so a value pushed this cycle is never popped
  // in the same cycle.
  assign pop   = !empty && ((state == IDLE) || (hold_cnt == '0));

  sync_fifo #(
    .WIDTH (LED_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_25mhz (clk_25mhz),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .din       (wdata[LED_WIDTH-1:0]),
    .dout      (fifo_dout),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  // Display FSM: load a value, hold it HOLD_CYCLES clocks, chain if more queued.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      led      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            led      <= fifo_dout;
            hold_cnt <= HOLD_LAST;
            state    <= SHOW;
          end
        end
        SHOW: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (!empty) begin
            led      <= fifo_dout;
            hold_cnt <= HOLD_LAST;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LED_READBACK_EN
  // Readback is combinational from registers so software can poll occupancy.
  always_comb begin
    rdata = '0;
    if (read_en && hit) begin
      rdata[31:24]          = 8'(fifo_count);
      rdata[LED_WIDTH-1:0]  = led;
    end
  end
`else
  assign rdata = '0;
`endif

  // Upper store bits and (without readback) read_en are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{wdata, read_en};

endmodule

// File: tb/tb_led_output_port.sv
// Randomised scoreboard bench for led_output_port (HOLD_CYCLES=4, DEPTH=4).
// The reference model works at transaction level: each accepted store i gets
// a display start edge S_i = max(S_{i-1} + HOLD, A_i + 1), where A_i is the
// acceptance edge; occupancy is accepted-minus-displayed up to an edge.
module tb_led_output_port;

  localparam int          HOLD  = 4;
  localparam int          DEPTH = 4;
  localparam int          LW    = 8;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk_25mhz = 1'b0;
  logic        reset_n   = 1'b0;
  logic [31:0] addr      = '0;
  logic [31:0] wdata     = '0;
  logic        write_en  = 1'b0;
  logic        read_en   = 1'b0;
  logic [31:0] rdata;
  logic        stall;
  logic [LW-1:0] led;
  logic [2:0]  fifo_count;

  led_output_port #(
    .BASE_ADDR   (BASE),
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD),
    .LED_WIDTH   (LW)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .reset_n    (reset_n),
    .addr       (addr),
    .wdata      (wdata),
    .write_en   (write_en),
    .read_en    (read_en),
    .rdata      (rdata),
    .stall      (stall),
    .led        (led),
    .fifo_count (fifo_count)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  typedef struct {
    logic [7:0] v;
    int         s;
  } disp_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         acc_a[$];
  int         acc_s[$];
  logic [7:0] acc_v[$];
  disp_t      exp_q[$];
  logic [7:0] prev_led  = 8'h00;
  logic [7:0] last_val  = 8'h00;
  bit         st6;

  // Edge counter since reset release; edge e is the e-th rising edge.
  always @(posedge clk_25mhz) begin
    if (!reset_n) cyc = 0;
    else          cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int occ(input int e);
    int n = 0;
    foreach (acc_a[i]) begin
      if (acc_a[i] <= e) n++;
      if (acc_s[i] <= e) n--;
    end
    return n;
  endfunction

  function automatic logic [7:0] model_led(input int e);
    logic [7:0] v = 8'h00;
    foreach (acc_s[i]) if (acc_s[i] <= e) v = acc_v[i];
    return v;
  endfunction

  function automatic void model_clear();
    acc_a.delete();
    acc_s.delete();
    acc_v.delete();
    exp_q.delete();
    last_val = 8'h00;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic store(input logic [31:0] a, input logic [7:0] v, output bit stalled);
    bit          done  = 0;
    int          tries = 0;
    logic [31:0] r     = $urandom;
    bit          exp_st;
    int          a_e, s_e, last_s;
    stalled  = 0;
    addr     = a;
    wdata    = {r[31:8], v};
    write_en = 1'b1;
    read_en  = 1'b0;
    while (!done) begin
      #1;
      exp_st = (a == BASE) && (occ(cyc) >= DEPTH);
      chk("stall", 32'(stall), 32'(exp_st));
      if (stall) stalled = 1;
      if (a != BASE) begin
        done = 1;
      end else if (!exp_st) begin
        a_e    = cyc + 1;
        last_s = (acc_s.size() > 0) ? acc_s[$] : -1000;
        s_e    = (last_s + HOLD > a_e + 1) ? last_s + HOLD : a_e + 1;
        acc_a.push_back(a_e);
        acc_s.push_back(s_e);
        acc_v.push_back(v);
        exp_q.push_back('{v, s_e});
        last_val = v;
        done = 1;
      end else if (++tries > 50) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout: store %0h still stalled after 50 cycles", v);
        done = 1;
      end
      @(posedge clk_25mhz); #1;
    end
  endtask

  task automatic idle(input int n);
    write_en = 1'b0;
    read_en  = 1'b0;
    repeat (n) begin
      @(posedge clk_25mhz); #1;
    end
  endtask

  task automatic load(input logic [31:0] a);
    logic [31:0] exp;
    write_en = 1'b0;
    read_en  = 1'b1;
    addr     = a;
    #1;
    exp = '0;
`ifdef LED_READBACK_EN
    if (a == BASE) exp = {8'(occ(cyc)), 16'h0000, model_led(cyc)};
`endif
    chk("rdata", rdata, exp);
    @(posedge clk_25mhz); #1;
    read_en = 1'b0;
  endtask

  // Monitor: every LED change pops the scoreboard; occupancy checked each cycle.
  always @(negedge clk_25mhz) begin
    disp_t e;
    if (reset_n) begin
      if (led !== prev_led) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL led_unexpected: got %0h expected no change from %0h (edge %0d)", led, prev_led, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("led_value", 32'(led), 32'(e.v));
          chk("led_start_edge", cyc, e.s);
        end
      end
      chk("fifo_count", 32'(fifo_count), occ(cyc));
    end
    prev_led = led;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          st;
    logic [7:0]  v;
    logic [31:0] ra;
    int          op;

    // Reset state
    repeat (3) @(posedge clk_25mhz);
    #1;
    chk("reset_led", 32'(led), 0);
    chk("reset_fifo_count", 32'(fifo_count), 0);
    chk("reset_stall", 32'(stall), 0);
    chk("reset_rdata", rdata, 0);
    reset_n = 1'b1;
    @(posedge clk_25mhz); #1;

    // Single store
    store(BASE, 8'h78, st);
    idle(HOLD + 4);
    chk("single_led_holds", 32'(led), 32'h78);
    chk("single_fifo_empty", 32'(fifo_count), 0);

    // Burst of three
    store(BASE, 8'd15, st);
    store(BASE, 8'd29, st);
    store(BASE, 8'd42, st);
    idle(3 * HOLD + 4);

    // Fill and stall: the sixth store must see stall
    for (int i = 1; i <= 6; i++) begin
      store(BASE, 8'(i), st);
      if (i == 6) st6 = st;
    end
    chk("stall_on_6th", 32'(st6), 1);
    idle(6 * HOLD + 4);

    // Decode: other addresses ignored
    store(32'h8000_0004, 8'hFF, st);
    store(32'h0000_0000, 8'hFF, st);
    idle(3);
    chk("decode_led", 32'(led), 32'h06);

    // Readback with a value shown and two queued
    store(BASE, 8'h2A, st);
    store(BASE, 8'h11, st);
    store(BASE, 8'h22, st);
    load(BASE);
    load(32'h0000_0010);
    idle(3 * HOLD + 4);

    // Reset mid-operation: one displayed, three queued
    store(BASE, 8'h31, st);
    store(BASE, 8'h32, st);
    store(BASE, 8'h33, st);
    store(BASE, 8'h34, st);
    chk("pre_reset_count", 32'(fifo_count), 3);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("async_reset_led", 32'(led), 0);
    chk("async_reset_count", 32'(fifo_count), 0);
    idle(2);
    reset_n = 1'b1;
    @(posedge clk_25mhz); #1;
    store(BASE, 8'h5A, st);
    idle(HOLD + 3);
    chk("post_reset_led", 32'(led), 32'h5A);

    // Randomised traffic
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 7);
      if (op <= 4) begin
        do v = 8'($urandom_range(1, 255)); while (v == last_val);
        store(BASE, v, st);
      end else if (op == 5) begin
        ra = $urandom;
        if (ra == BASE) ra = ra ^ 32'h1;
        store(ra, 8'($urandom), st);
      end else if (op == 6) begin
        load(($urandom_range(0, 1) == 0) ? BASE : 32'h8000_0008);
      end else begin
        idle($urandom_range(0, 2 * HOLD));
      end
    end

    idle(DEPTH * HOLD + HOLD + 6);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_output_port.md
Name: led_output_port

Overview:
- Memory-mapped output peripheral on the CPU data bus, in parallel with the data RAM.
- Captures CPU stores to the LED address (0x8000_0000) into a small FIFO.
- Presents each captured value on the board LEDs for a fixed, human-visible hold time, so fast store sequences (e.g. a summation loop) remain observable.
- Stalls the CPU store when the FIFO is full.

Parameters:
- BASE_ADDR, 32'h8000_0000, word address decoded as the LED port.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- HOLD_CYCLES, 25_000_000, clock cycles each value stays on the LEDs; minimum 1.
- LED_WIDTH, 8, number of LED outputs; must be ≤ 32.

Ports:
- clk_25mhz  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- addr  input  32  CPU data address
- wdata  input  32  CPU store data
- write_en  input  1  CPU store strobe, one cycle per store
- read_en  input  1  CPU load strobe
- rdata  output  32  load data, valid in the cycle read_en and an address match are both high
- stall  output  1  CPU must hold the store; combinational
- led  output  LED_WIDTH  LED drive, registered
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy, registered

Behaviour:
- Reset (async assert, sync release):
  - led=0, fifo_count=0, FIFO pointers=0.
  - state=IDLE, hold counter=0, rdata=0.
  - A reset mid-hold discards FIFO contents and the current display.
- Decode:
  - hit = (addr == BASE_ADDR).
  - Only write_en && hit affects this block; all other addresses are ignored.
- Push and stall:
  - push = write_en && hit && !full.
  - stall = write_en && hit && full, where full is registered (fifo_count == DEPTH).
  - A pop in the same cycle does not clear stall; the store is accepted the following cycle.
  - Only wdata[LED_WIDTH-1:0] is stored; upper bits are discarded.
- Display FSM, states IDLE and SHOW:
  - IDLE: if FIFO non-empty, pop. led <= popped data, counter <= HOLD_CYCLES-1, go to SHOW. Otherwise led holds its last value.
  - SHOW: if counter != 0, decrement. If counter == 0 and FIFO non-empty, pop back-to-back (led updates, counter reloads, stay in SHOW). If counter == 0 and FIFO empty, go to IDLE.
- Latency:
  - A store accepted at rising edge E into an empty FIFO with the FSM in IDLE appears on led after edge E+1.
  - Each value is displayed for exactly HOLD_CYCLES cycles whenever a successor is queued.
- Simultaneous push and pop: allowed; fifo_count is unchanged. A push into an empty FIFO is never popped in the same cycle.
- Count and pointers:
  - fifo_count updates on the same edge as push and pop.
  - Pointers wrap modulo DEPTH.
- rdata:
  - Without the optional feature: always 0.
  - Loads never stall.

Optional Feature:
- Macro: LED_READBACK_EN.
- Defined: read_en && hit returns {fifo_count zero-extended into bits 31:24, led zero-extended into bits LED_WIDTH-1:0}. The value is combinational from registers, so software can poll FIFO occupancy.
- Undefined: rdata tied to 0 and read_en unused.

Decomposition:
- Shared package/include:
  - LED_BASE_ADDR constant (also used by the top-level address decoder).
  - FSM state encoding: IDLE=1'b0, SHOW=1'b1.
- One sub-module: sync_fifo, a parameterised width/depth single-clock FIFO.
  - Inputs: push, pop, din.
  - Outputs: dout (first-word presented), count, full, empty.
  - Resets with the same reset_n.
- The FSM, hold counter and decode live in led_output_port.

Test Plan:
- Bench parameters for all scenarios: HOLD_CYCLES=4, DEPTH=4.
- Single store: reset, store 0x0000_0078 to 0x8000_0000 -> led=0x78 one edge after acceptance; fifo_count returns to 0; FSM returns to IDLE after 4 cycles; led stays 0x78.
- Burst: store 15, 29, 42 on consecutive cycles -> no stall; led shows 15, 29, 42 for exactly 4 cycles each.
- Full/stall: store 1..6 back-to-back -> stall asserts on the 6th store (FIFO full after 1 popped + 4 queued); the store completes after the next pop; all 6 values are displayed in order.
- Decode: store 0xFF to 0x8000_0004 and to 0x0000_0000 -> led, fifo_count and stall unchanged.
- Reset mid-operation: deassert reset_n asynchronously while 3 values are queued and one is displayed -> led=0 and fifo_count=0 immediately; after release the next store displays normally.
- Readback (LED_READBACK_EN defined): with led=0x2A and 2 entries queued, load 0x8000_0000 -> rdata=0x0200_002A; with the macro undefined -> rdata=0.
